add_arbiter: RTL

Two-port round-robin scheduler that shares the single-cycle 32-bit adder datapath between two requesters. Accepts one add per grant, runs it as one pass (narrow, W bits) or two chained passes (wide, 2W bits, low half then high half with carry), and returns a registered result with Z/N/C/V flags and the ID of the served requester. Sits between the ALU front end and the shared adder.

---
 rtl/add_arbiter_if.sv | 37 +++
 rtl/add_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/add_arbiter_if.sv
// Request/grant/result bundle between the two ALU ports and the shared adder scheduler.
interface add_arbiter_if #(parameter int W = 32);
  logic           req0;
  logic [2*W-1:0] a0;
  logic [2*W-1:0] b0;
  logic           sgn0;
  logic           wide0;
  logic           req1;
  logic [2*W-1:0] a1;
  logic [2*W-1:0] b1;
  logic           sgn1;
  logic           wide1;
  logic           gnt0;
  logic           gnt1;
  logic           busy;
  logic           done;
  logic           done_id;
  logic [2*W-1:0] result;
  logic           z;
  logic           n;
  logic           c;
  logic           v;

  // Requester side: drives operands and requests, observes grants and results.
  modport master (
    output req0, a0, b0, sgn0, wide0,
    output req1, a1, b1, sgn1, wide1,
    input  gnt0, gnt1, busy, done, done_id, result, z, n, c, v
  );

  // Scheduler side.
  modport slave (
    input  req0, a0, b0, sgn0, wide0,
    input  req1, a1, b1, sgn1, wide1,
    output gnt0, gnt1, busy, done, done_id, result, z, n, c, v
  );
endinterface

// File: rtl/add_arbiter.sv
// Round-robin scheduler sharing one W-bit adder between two requesters.
// Wide (2W) adds run as two chained passes: low half, then high half with carry.
//
// state | meaning
// IDLE  | waiting for a request; captures operands of the selected port
// LO    | grant pulse; low-half add (whole op when narrow)
// HI    | high-half add with carry from LO (wide ops only)
// DONE  | result-valid pulse
module add_arbiter #(
  parameter int W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  add_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t         state_q, state_d;
  logic           last_q, last_d;
  logic           id_q, sgn_q, wide_q;
  logic [2*W-1:0] a_q, b_q;
  logic [W-1:0]   sum_lo_q;
  logic           carry_lo_q;
  logic [2*W-1:0] result_q, result_d;
  logic           z_q, n_q, c_q, v_q, done_id_q;
  logic           z_d, n_d, c_d, v_d;

  logic           any_req, sel_id, capture, flag_load;
  logic [W-1:0]   add_a, add_b, add_sum;
  logic           add_cin, add_co;
  logic [W:0]     add_full;

  // Port selection: a tie goes to the port not served last.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    sel_id  = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
    capture = (state_q == S_IDLE) & any_req;
  end

  // State register; last_q resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: if (any_req) begin
        state_d = S_LO;
        last_d  = sel_id;
      end
      S_LO:   state_d = wide_q ? S_HI : S_DONE;
      S_HI:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shared adder: low halves with no carry in LO, high halves plus stored carry in HI.
  always_comb begin
    add_a    = (state_q == S_HI) ? a_q[2*W-1:W] : a_q[W-1:0];
    add_b    = (state_q == S_HI) ? b_q[2*W-1:W] : b_q[W-1:0];
    add_cin  = (state_q == S_HI) & carry_lo_q;
    add_full = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    add_sum  = add_full[W-1:0];
    add_co   = add_full[W];
  end

  // Flags of the completing pass; the top bit of add_a/add_b/add_sum is bit M of the op.
  always_comb begin
    flag_load = ((state_q == S_LO) & ~wide_q) | (state_q == S_HI);
    if (state_q == S_HI) begin
      result_d = {add_sum, sum_lo_q};
      z_d      = (add_sum == '0) & (sum_lo_q == '0);
    end else begin
      result_d = {{W{1'b0}}, add_sum};
      z_d      = (add_sum == '0);
    end
    c_d = add_co;
    n_d = sgn_q & add_sum[W-1];
    v_d = sgn_q & (add_a[W-1] == add_b[W-1]) & (add_sum[W-1] != add_a[W-1]);
  end

  // Operand capture on the IDLE->LO edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      wide_q <= 1'b0;
      id_q   <= 1'b0;
    end else if (capture) begin
      a_q    <= sel_id ? bus.a1    : bus.a0;
      b_q    <= sel_id ? bus.b1    : bus.b0;
      sgn_q  <= sel_id ? bus.sgn1  : bus.sgn0;
      wide_q <= sel_id ? bus.wide1 : bus.wide0;
      id_q   <= sel_id;
    end
  end

  // Low-half sum/carry for the HI pass, and the held result/flags of the last op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_lo_q   <= '0;
      carry_lo_q <= 1'b0;
      result_q   <= '0;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
      c_q        <= 1'b0;
      v_q        <= 1'b0;
      done_id_q  <= 1'b0;
    end else begin
      if (state_q == S_LO) begin
        sum_lo_q   <= add_sum;
        carry_lo_q <= add_co;
      end
      if (flag_load) begin
        result_q  <= result_d;
        z_q       <= z_d;
        n_q       <= n_d;
        c_q       <= c_d;
        v_q       <= v_d;
        done_id_q <= id_q;
      end
    end
  end

  // Outputs decoded from state; result side comes straight from registers.
  always_comb begin
    bus.gnt0    = (state_q == S_LO) & ~id_q;
    bus.gnt1    = (state_q == S_LO) &  id_q;
    bus.busy    = (state_q != S_IDLE);
    bus.done    = (state_q == S_DONE);
    bus.done_id = done_id_q;
    bus.result  = result_q;
    bus.z       = z_q;
    bus.n       = n_q;
    bus.c       = c_q;
    bus.v       = v_q;
  end

endmodule
